cam_video_pipeline: RTL and testbench

Parametrised camera-to-LCD pixel front-end that replaces per-mode display modules with one runtime-selectable pipeline. It takes the camera byte stream (pixdata, hsync as line-valid, vsync as frame pulse), assembles RGB565 pixels, and applies one of four processing modes: colour, grayscale, binary threshold or invert. It drives the LCD RGB/DE/sync pins in the PixelClk domain. It sits directly between the camera pins and the LCD pins in top.

---
 rtl/cam_video_pipeline_if.sv | 36 +++
 rtl/cam_video_pipeline.sv | 275 +++++++++++++++++++++++++++
 tb/tb_cam_video_pipeline.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_video_pipeline_if.sv
// rtl/cam_video_pipeline_if.sv - camera byte stream in, LCD pixel stream out
interface cam_video_pipeline_if #(
  parameter int IN_W     = 8,
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5
);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  logic [IN_W-1:0] pixdata;
  logic            hsync;
  logic            vsync;
  logic            LCD_DE;
  logic            LCD_HSYNC;
  logic            LCD_VSYNC;
  logic [R_W-1:0]  LCD_R;
  logic [G_W-1:0]  LCD_G;
  logic [B_W-1:0]  LCD_B;
  logic [XW-1:0]   pix_x;
  logic [YW-1:0]   pix_y;

  // camera side: drives the byte stream, observes the LCD stream
  modport master (
    output pixdata, hsync, vsync,
    input  LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, pix_x, pix_y
  );

  // pipeline side: consumes the byte stream, drives the LCD stream
  modport slave (
    input  pixdata, hsync, vsync,
    output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, pix_x, pix_y
  );
endinterface

// File: rtl/cam_video_pipeline.sv
// rtl/cam_video_pipeline.sv - camera RGB565 capture, mode processing, LCD drive (option: CAM_TEST_PATTERN_EN)
module cam_video_pipeline #(
  parameter int IN_W     = 8,
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5,
  parameter int LAT      = 3
) (
  input  logic                 PixelClk,
  input  logic                 reset,
  cam_video_pipeline_if.slave  io,
  input  logic [1:0]           mode,
  input  logic [7:0]           threshold,
`ifdef CAM_TEST_PATTERN_EN
  input  logic                 test_pat,
`endif
  output logic                 frame_done,
  output logic                 ovf
);
  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(V_ACTIVE);
  // counters carry one extra bit so they can sit at the limit and flag overflow
  localparam int XCW = XW + 1;
  localparam int YCW = YW + 1;
  // capture and luma stages are fixed; the remaining latency is a plain delay line
  localparam int DL  = LAT - 2;
  localparam logic [XCW-1:0] H_LIM = XCW'(H_ACTIVE);
  localparam logic [YCW-1:0] V_LIM = YCW'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;

  state_t           state, state_nx;
  logic             frame_start, frame_end;
  logic             vsync_q, hsync_q;
  logic             vs_fall, vs_rise, hs_fall;
  logic [1:0]       mode_l;
  logic [7:0]       thr_l;
  logic             phase;
  logic [7:0]       hi_byte;
  logic [XCW-1:0]   x_cnt;
  logic [YCW-1:0]   y_cnt;
  logic             pix_valid, pix_keep;
  logic [15:0]      src_pix;

  logic             s1_valid;
  logic [15:0]      s1_pix;
  logic [XW-1:0]    s1_x;
  logic [YW-1:0]    s1_y;
  logic [7:0]       r8, g8, b8;
  logic [15:0]      acc;

  logic             s2_valid;
  logic [15:0]      s2_pix;
  logic [15:0]      s2_acc;
  logic [XW-1:0]    s2_x;
  logic [YW-1:0]    s2_y;
  logic [15:0]      proc;
  logic [R_W-1:0]   r_adj;
  logic [G_W-1:0]   g_adj;
  logic [B_W-1:0]   b_adj;

  logic             d_de [DL];
  logic [R_W-1:0]   d_r  [DL];
  logic [G_W-1:0]   d_g  [DL];
  logic [B_W-1:0]   d_b  [DL];
  logic [XW-1:0]    d_x  [DL];
  logic [YW-1:0]    d_y  [DL];
  logic [LAT-1:0]   hs_dly, vs_dly;

`ifdef CAM_TEST_PATTERN_EN
  logic             pat_l;
  logic [2:0]       bar;
  assign bar = 3'((32'(x_cnt) * 8) / H_ACTIVE);
`endif

  assign vs_fall   = vsync_q & ~io.vsync;
  assign vs_rise   = ~vsync_q & io.vsync;
  assign hs_fall   = hsync_q & ~io.hsync;
  assign pix_valid = (state == ACTIVE) && io.hsync && phase;
  assign pix_keep  = pix_valid && (x_cnt < H_LIM) && (y_cnt < V_LIM);

  // frame state register
  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // frame sequencing: capture only between a vsync fall and the next rise
  always_comb begin
    state_nx    = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE:       state_nx = WAIT_FRAME;
      WAIT_FRAME: if (vs_fall) begin
                    state_nx    = ACTIVE;
                    frame_start = 1'b1;
                  end
      ACTIVE:     if (vs_rise) begin
                    state_nx  = WAIT_FRAME;
                    frame_end = 1'b1;
                  end
      default:    state_nx = IDLE;
    endcase
  end

  // byte pairing, per-frame settings, column/row counters and overflow flag
  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      vsync_q    <= 1'b0;
      hsync_q    <= 1'b0;
      frame_done <= 1'b0;
      mode_l     <= '0;
      thr_l      <= '0;
      phase      <= 1'b0;
      hi_byte    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      ovf        <= 1'b0;
`ifdef CAM_TEST_PATTERN_EN
      pat_l      <= 1'b0;
`endif
    end else begin
      vsync_q    <= io.vsync;
      hsync_q    <= io.hsync;
      frame_done <= frame_end;
      if (frame_start) begin
        mode_l <= mode;
        thr_l  <= threshold;
`ifdef CAM_TEST_PATTERN_EN
        pat_l  <= test_pat;
`endif
      end
      if (state != ACTIVE || frame_end || !io.hsync) phase <= 1'b0;
      else                                           phase <= ~phase;
      if (io.hsync && !phase) hi_byte <= io.pixdata[7:0];
      if (state != ACTIVE || frame_end) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (hs_fall) begin
        x_cnt <= '0;
        if (x_cnt != '0 && y_cnt < V_LIM) y_cnt <= y_cnt + YCW'(1);
      end else if (pix_valid && x_cnt < H_LIM) begin
        x_cnt <= x_cnt + XCW'(1);
      end
      if (pix_valid && !pix_keep) ovf <= 1'b1;
    end
  end

  // pixel source: camera pair, or colour bars when the test pattern is latched
  always_comb begin
    src_pix = {hi_byte, io.pixdata[7:0]};
`ifdef CAM_TEST_PATTERN_EN
    if (pat_l) begin
      case (bar)
        3'd0:    src_pix = 16'hFFFF;
        3'd1:    src_pix = 16'hFFE0;
        3'd2:    src_pix = 16'h07FF;
        3'd3:    src_pix = 16'h07E0;
        3'd4:    src_pix = 16'hF81F;
        3'd5:    src_pix = 16'hF800;
        3'd6:    src_pix = 16'h001F;
        default: src_pix = 16'h0000;
      endcase
    end
`endif
  end

  // stage 1: register the assembled pixel and its coordinates
  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= pix_keep;
      s1_pix   <= src_pix;
      s1_x     <= x_cnt[XW-1:0];
      s1_y     <= y_cnt[YW-1:0];
    end
  end

  // 565 -> 888 by MSB replication, then weighted luma sum (max 65280, fits 16 bits)
  always_comb begin
    r8  = {s1_pix[15:11], s1_pix[15:13]};
    g8  = {s1_pix[10:5],  s1_pix[10:9]};
    b8  = {s1_pix[4:0],   s1_pix[4:2]};
    acc = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
  end

  // stage 2: register luma accumulator alongside the raw pixel
  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_pix   <= '0;
      s2_acc   <= '0;
      s2_x     <= '0;
      s2_y     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_pix   <= s1_pix;
      s2_acc   <= acc;
      s2_x     <= s1_x;
      s2_y     <= s1_y;
    end
  end

  // mode select and output width adaptation; Y >= thr is tested as acc >= thr*256
  always_comb begin
    case (mode_l)
      2'd0:    proc = s2_pix;
      2'd1:    proc = {s2_acc[15:11], s2_acc[15:10], s2_acc[15:11]};
      2'd2:    proc = (s2_acc >= {thr_l, 8'h00}) ? 16'hFFFF : 16'h0000;
      default: proc = ~s2_pix;
    endcase
    r_adj = '0;
    g_adj = '0;
    b_adj = '0;
    for (int i = 0; i < R_W; i++) r_adj[R_W-1-i] = proc[15 - (i % 5)];
    for (int i = 0; i < G_W; i++) g_adj[G_W-1-i] = proc[10 - (i % 6)];
    for (int i = 0; i < B_W; i++) b_adj[B_W-1-i] = proc[4 - (i % 5)];
  end

  // output stage plus padding delay; RGB and coordinates are zero outside DE
  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DL; i++) begin
        d_de[i] <= 1'b0;
        d_r[i]  <= '0;
        d_g[i]  <= '0;
        d_b[i]  <= '0;
        d_x[i]  <= '0;
        d_y[i]  <= '0;
      end
    end else begin
      d_de[0] <= s2_valid;
      d_r[0]  <= s2_valid ? r_adj : '0;
      d_g[0]  <= s2_valid ? g_adj : '0;
      d_b[0]  <= s2_valid ? b_adj : '0;
      d_x[0]  <= s2_valid ? s2_x  : '0;
      d_y[0]  <= s2_valid ? s2_y  : '0;
      for (int i = 1; i < DL; i++) begin
        d_de[i] <= d_de[i-1];
        d_r[i]  <= d_r[i-1];
        d_g[i]  <= d_g[i-1];
        d_b[i]  <= d_b[i-1];
        d_x[i]  <= d_x[i-1];
        d_y[i]  <= d_y[i-1];
      end
    end
  end

  // sync pass-through delayed by the same LAT registers as the data path
  always_ff @(posedge PixelClk or posedge reset) begin
    if (reset) begin
      hs_dly <= '0;
      vs_dly <= '0;
    end else begin
      hs_dly <= {hs_dly[LAT-2:0], io.hsync};
      vs_dly <= {vs_dly[LAT-2:0], io.vsync};
    end
  end

  assign io.LCD_DE    = d_de[DL-1];
  assign io.LCD_R     = d_r[DL-1];
  assign io.LCD_G     = d_g[DL-1];
  assign io.LCD_B     = d_b[DL-1];
  assign io.pix_x     = d_x[DL-1];
  assign io.pix_y     = d_y[DL-1];
  assign io.LCD_HSYNC = hs_dly[LAT-1];
  assign io.LCD_VSYNC = vs_dly[LAT-1];
endmodule

// File: tb/tb_cam_video_pipeline.sv
// tb/tb_cam_video_pipeline.sv - directed scoreboard bench for cam_video_pipeline
module tb_cam_video_pipeline;
  localparam int H   = 800;
  localparam int V   = 480;
  localparam int LAT = 3;

  typedef struct {
    logic [15:0] rgb;
    int          x;
    int          y;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] threshold = 8'd0;
  logic       frame_done, ovf;

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          mx, my;
  bit          m_active = 1'b0;
  logic [1:0]  f_mode;
  logic [7:0]  f_thr;
  int          de_count = 0;
  int          fd_count = 0;
  int          last_y = -1;
  logic [15:0] last_rgb = '0;
  bit          chk_sync = 1'b0;
  logic [2:0]  vs_hist = '0;
  logic [2:0]  hs_hist = '0;
  int          p127, p128, de0, fd0;
  logic [15:0] q;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cam_video_pipeline_if #(.IN_W(8), .H_ACTIVE(H), .V_ACTIVE(V), .R_W(5), .G_W(6), .B_W(5)) io ();

  cam_video_pipeline #(
    .IN_W(8), .H_ACTIVE(H), .V_ACTIVE(V), .R_W(5), .G_W(6), .B_W(5), .LAT(LAT)
  ) dut (
    .PixelClk   (clk),
    .reset      (rst),
    .io         (io),
    .mode       (mode),
    .threshold  (threshold),
`ifdef CAM_TEST_PATTERN_EN
    .test_pat   (1'b0),
`endif
    .frame_done (frame_done),
    .ovf        (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic int luma(input logic [15:0] p);
    int r8, g8, b8;
    r8 = (int'(p[15:11]) << 3) | (int'(p[15:11]) >> 2);
    g8 = (int'(p[10:5]) << 2) | (int'(p[10:5]) >> 4);
    b8 = (int'(p[4:0]) << 3) | (int'(p[4:0]) >> 2);
    return (77 * r8 + 150 * g8 + 29 * b8) >> 8;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] p, input logic [1:0] md, input logic [7:0] th);
    logic [7:0] y;
    y = 8'(luma(p));
    case (md)
      2'd0:    return p;
      2'd1:    return {y[7:3], y[7:2], y[7:3]};
      2'd2:    return (int'(y) >= int'(th)) ? 16'hFFFF : 16'h0000;
      default: return ~p;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_frame();
    io.vsync = 1'b0;
    f_mode   = mode;
    f_thr    = threshold;
    mx       = 0;
    my       = 0;
    m_active = 1'b1;
    idle(3);
  endtask

  task automatic end_frame();
    io.vsync = 1'b1;
    m_active = 1'b0;
    idle(6);
  endtask

  task automatic send_byte(input logic [7:0] b);
    io.hsync   = 1'b1;
    io.pixdata = b;
    tick();
  endtask

  task automatic send_pix(input logic [15:0] p);
    send_byte(p[15:8]);
    io.pixdata = p[7:0];
    if (m_active) begin
      if (mx < H && my < V)
        sb.push_back('{rgb: model(p, f_mode, f_thr), x: mx, y: my, cyc: cyc});
      if (mx < H) mx++;
    end
    tick();
  endtask

  task automatic end_line();
    io.hsync   = 1'b0;
    io.pixdata = '0;
    if (m_active && mx != 0 && my < V) my++;
    mx = 0;
    idle(2);
  endtask

  // output monitor: pops the scoreboard on every DE and tracks sync alignment
  always @(negedge clk) begin
    if (!rst) begin
      if (io.LCD_DE) begin
        de_count++;
        last_rgb = {io.LCD_R, io.LCD_G, io.LCD_B};
        last_y   = int'(io.pix_y);
        if (sb.size() == 0) begin
          check("unexpected_de", 32'(io.LCD_DE), 32'd0);
        end else begin
          e = sb.pop_front();
          check("pix_rgb", 32'(last_rgb), 32'(e.rgb));
          check("pix_x", 32'(io.pix_x), e.x);
          check("pix_y", 32'(io.pix_y), e.y);
          check("latency", cyc - e.cyc, LAT);
        end
      end else begin
        check("idle_rgb", 32'({io.LCD_R, io.LCD_G, io.LCD_B}), 32'd0);
      end
      if (frame_done) fd_count++;
      if (chk_sync) begin
        check("vsync_dly", 32'(io.LCD_VSYNC), 32'(vs_hist[2]));
        check("hsync_dly", 32'(io.LCD_HSYNC), 32'(hs_hist[2]));
      end
      vs_hist = {vs_hist[1:0], io.vsync};
      hs_hist = {hs_hist[1:0], io.hsync};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    io.pixdata = '0;
    io.hsync   = 1'b0;
    io.vsync   = 1'b1;
    p127 = -1;
    p128 = -1;
    for (int i = 0; i < 65536; i++) begin
      q = 16'(i);
      if (p127 < 0 && luma(q) == 127) p127 = i;
      if (p128 < 0 && luma(q) == 128) p128 = i;
    end
    check("luma127_exists", 32'(p127 >= 0), 32'd1);
    check("luma128_exists", 32'(p128 >= 0), 32'd1);

    idle(3);
    check("rst_de", 32'(io.LCD_DE), 32'd0);
    check("rst_rgb", 32'({io.LCD_R, io.LCD_G, io.LCD_B}), 32'd0);
    check("rst_xy", 32'({io.pix_x, io.pix_y}), 32'd0);
    check("rst_syncs", 32'({io.LCD_HSYNC, io.LCD_VSYNC}), 32'd0);
    check("rst_flags", 32'({frame_done, ovf}), 32'd0);
    rst = 1'b0;
    idle(5);
    chk_sync = 1'b1;

    // bytes before the first vsync fall must be ignored
    de0 = de_count;
    send_pix(16'h1234);
    send_pix(16'h5678);
    end_line();
    idle(5);
    check("pre_frame_no_de", de_count - de0, 0);

    // mode 0 then mode 3 with 0xF800
    mode = 2'd0;
    start_frame();
    send_pix(16'hF800);
    end_line();
    idle(3);
    check("m0_f800", 32'(last_rgb), 32'h0000F800);
    end_frame();
    mode = 2'd3;
    start_frame();
    send_pix(16'hF800);
    send_pix(16'h1357);
    end_line();
    idle(3);
    check("m3_last", 32'(last_rgb), 32'h0000ECA8);
    end_frame();

    // grayscale extremes
    mode = 2'd1;
    start_frame();
    send_pix(16'hFFFF);
    end_line();
    idle(3);
    check("m1_white", 32'(last_rgb), 32'h0000FFFF);
    send_pix(16'h0000);
    send_pix(16'hA5C3);
    end_line();
    end_frame();

    // binary threshold at 127/128, threshold change mid-frame held off
    mode = 2'd2;
    threshold = 8'd128;
    start_frame();
    send_pix(16'(p127));
    end_line();
    idle(3);
    check("m2_y127", 32'(last_rgb), 32'h00000000);
    send_pix(16'(p128));
    end_line();
    idle(3);
    check("m2_y128", 32'(last_rgb), 32'h0000FFFF);
    threshold = 8'd0;
    send_pix(16'(p127));
    end_line();
    idle(3);
    check("m2_thr_held", 32'(last_rgb), 32'h00000000);
    end_frame();
    start_frame();
    send_pix(16'(p127));
    end_line();
    idle(3);
    check("m2_thr_new", 32'(last_rgb), 32'h0000FFFF);
    end_frame();

    // reset mid-line with DE high
    mode = 2'd0;
    start_frame();
    io.hsync = 1'b1;
    for (int i = 0; i < 20; i++) begin
      io.pixdata = 8'(i + 1);
      tick();
      if (io.LCD_DE) break;
    end
    check("mid_de_seen", 32'(io.LCD_DE), 32'd1);
    chk_sync = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_de", 32'(io.LCD_DE), 32'd0);
    check("mid_rst_rgb", 32'({io.LCD_R, io.LCD_G, io.LCD_B}), 32'd0);
    check("mid_rst_syncs", 32'({io.LCD_HSYNC, io.LCD_VSYNC}), 32'd0);
    sb.delete();
    m_active = 1'b0;
    idle(2);
    rst = 1'b0;
    de0 = de_count;
    for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i));
    end_line();
    idle(5);
    chk_sync = 1'b1;
    check("post_rst_no_de", de_count - de0, 0);
    end_frame();
    start_frame();
    send_pix(16'hC0DE);
    send_pix(16'h0F0F);
    end_line();
    end_frame();

    // full frame of 480 lines
    mode = 2'd3;
    fd0 = fd_count;
    start_frame();
    for (int ln = 0; ln < V; ln++) begin
      send_pix(16'($urandom));
      end_line();
    end
    idle(3);
    check("last_row", last_y, V - 1);
    end_frame();
    check("frame_done_once", fd_count - fd0, 1);
    check("ovf_clear", 32'(ovf), 32'd0);

    // over-long line and odd-length line
    mode = 2'd0;
    start_frame();
    de0 = de_count;
    for (int i = 0; i < 801; i++) send_pix(16'(i * 3 + 1));
    end_line();
    idle(4);
    check("long_line_de", de_count - de0, H);
    check("ovf_set", 32'(ovf), 32'd1);
    de0 = de_count;
    send_pix(16'h1111);
    send_pix(16'h2222);
    send_pix(16'h3333);
    send_byte(8'h44);
    end_line();
    idle(4);
    check("odd_line_de", de_count - de0, 3);
    end_frame();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
